// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//   Sequential front/back end for an external combinational 8-bit ALU
//   (ADD=000, SUB=001, AND=010, OR=011, NOT=100).
//   Commands are buffered in a small FIFO. Each command is issued to the ALU
//   through registered operand/opcode outputs that stay stable. One cycle later
//   the ALU result is captured into a held result register, which the consumer
//   accepts with a valid/ready handshake.
//
// Ports
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready = FIFO not full
//   cmd_a, cmd_b, cmd_op command operands and opcode
//   alu_a, alu_b, alu_op registered operands/opcode driven to the ALU
//   alu_result           combinational ALU result
//   res_valid/res_ready  result handshake
//   res_data             captured result
//   res_zero             res_data == 0
//   res_illegal          captured opcode was above 3'b100
//   fifo_count           number of buffered commands (AW+1 bits)
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic [2:0]    cmd_op,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_op,
  input  logic [7:0]    alu_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [7:0]    res_data,
  output logic          res_zero,
  output logic          res_illegal,
  output logic [AW:0]   fifo_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
  } cmd_t;

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [2:0]    MAX_LEGAL  = 3'b100;

  cmd_t          mem [DEPTH];
  cmd_t          head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          have_cmd;
  state_t        state;

  // NOTE: cmd_ready looks only at the registered count, so a full FIFO refuses
  // a push even when the FSM pops in the same cycle; this keeps cmd_ready free
  // of any combinational path from res_ready.
  assign cmd_ready  = (count != FULL_COUNT);
  assign push       = cmd_valid && cmd_ready;
  assign have_cmd   = (count != '0);
  assign pop        = have_cmd && ((state == IDLE) || ((state == HOLD) && res_ready));
  assign head       = mem[rd_ptr];
  assign fifo_count = count;

  // NOTE: the storage array has no reset; stale entries are unreachable
  // because count and the pointers are reset, and leaving it unreset lets it
  // map onto plain flops/RAM without reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, op: cmd_op};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sequencer FSM: every output is a register, alu_* change only on a pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
      res_zero    <= 1'b0;
      res_illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            alu_a  <= head.a;
            alu_b  <= head.b;
            alu_op <= head.op;
            state  <= EXEC;
          end
        end
        EXEC: begin
          // Operands have been stable for a full cycle; sample the ALU.
          res_data    <= alu_result;
          res_zero    <= (alu_result == 8'h00);
          res_illegal <= (alu_op > MAX_LEGAL);
          res_valid   <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (pop) begin
              alu_a  <= head.a;
              alu_b  <= head.b;
              alu_op <= head.op;
              state  <= EXEC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Directed bench for alu_cmd_sequencer. A behavioural 8-bit ALU closes the
//   loop from alu_a/alu_b/alu_op to alu_result. Inputs are driven and outputs
//   sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_a;
  logic [7:0]    cmd_b;
  logic [2:0]    cmd_op;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [2:0]    alu_op;
  logic [7:0]    alu_result;
  logic          res_valid;
  logic          res_ready;
  logic [7:0]    res_data;
  logic          res_zero;
  logic          res_illegal;
  logic [AW:0]   fifo_count;

  int vectors     = 0;
  int miscompares = 0;

  alu_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_op      (cmd_op),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_result  (alu_result),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_zero    (res_zero),
    .res_illegal (res_illegal),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  // External combinational ALU; undefined opcodes return 0.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      3'b100:  alu_result = ~alu_a;
      default: alu_result = 8'h00;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until accepted (bounded).
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit accepted;
    accepted  = 1'b0;
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    for (int i = 0; i < 20 && !accepted; i++) begin
      accepted = cmd_ready;
      step();
    end
    cmd_valid = 1'b0;
    if (!accepted) check("push_accept", 32'(accepted), 32'd1);
  endtask

  // Wait (bounded) for res_valid, then check the held result fields.
  task automatic wait_result(input string tag, input logic [7:0] data,
                             input logic zero, input logic illegal);
    for (int n = 0; n < 10 && !res_valid; n++) step();
    check({tag, "_valid"},   32'(res_valid),   32'd1);
    check({tag, "_data"},    32'(res_data),    32'(data));
    check({tag, "_zero"},    32'(res_zero),    32'(zero));
    check({tag, "_illegal"}, 32'(res_illegal), 32'(illegal));
  endtask

  // One-cycle res_ready pulse to consume the held result.
  task automatic consume();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] drain_exp [4];
    drain_exp = '{8'h04, 8'h06, 8'h08, 8'h0A};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = '0;
    res_ready = 1'b0;

    // ---------------- reset values ----------------
    step();
    step();
    check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    check("rst_res_valid",  32'(res_valid),  32'd0);
    check("rst_res_data",   32'(res_data),   32'd0);
    check("rst_alu_a",      32'(alu_a),      32'd0);
    check("rst_alu_op",     32'(alu_op),     32'd0);
    rst_n = 1'b1;
    step();

    // ---------------- single ADD, latency ----------------
    cmd_valid = 1'b1; cmd_a = 8'h7F; cmd_b = 8'h01; cmd_op = 3'b000;
    step();                                   // E0: accepted
    cmd_valid = 1'b0;
    check("add_count_e0",  32'(fifo_count), 32'd1);
    check("add_valid_e0",  32'(res_valid),  32'd0);
    step();                                   // E1: issued
    check("add_alu_a_e1",  32'(alu_a),      32'h7F);
    check("add_alu_b_e1",  32'(alu_b),      32'h01);
    check("add_valid_e1",  32'(res_valid),  32'd0);
    check("add_count_e1",  32'(fifo_count), 32'd0);
    step();                                   // E2: result held
    check("add_valid_e2",  32'(res_valid),  32'd1);
    check("add_data_e2",   32'(res_data),   32'h80);
    check("add_zero_e2",   32'(res_zero),   32'd0);
    step();
    check("add_hold_valid", 32'(res_valid), 32'd1);
    check("add_hold_data",  32'(res_data),  32'h80);
    consume();
    check("add_after_consume", 32'(res_valid), 32'd0);

    // ---------------- zero results ----------------
    push_cmd(8'h05, 8'h05, 3'b001);
    wait_result("sub_zero", 8'h00, 1'b1, 1'b0);
    consume();
    push_cmd(8'hFF, 8'h01, 3'b000);
    wait_result("add_wrap", 8'h00, 1'b1, 1'b0);
    consume();
    step();

    // ---------------- backpressure ----------------
    push_cmd(8'h01, 8'h01, 3'b000);
    push_cmd(8'h02, 8'h02, 3'b000);
    push_cmd(8'h03, 8'h03, 3'b000);
    push_cmd(8'h04, 8'h04, 3'b000);
    push_cmd(8'h05, 8'h05, 3'b000);
    check("bp_full_ready", 32'(cmd_ready),  32'd0);
    check("bp_full_count", 32'(fifo_count), 32'd4);
    check("bp_first_data", 32'(res_data),   32'h02);
    // Extra command offered while full must be refused.
    cmd_valid = 1'b1; cmd_a = 8'h10; cmd_b = 8'h10; cmd_op = 3'b000;
    step();
    step();
    check("bp_refuse_count", 32'(fifo_count), 32'd4);
    check("bp_stable_data",  32'(res_data),   32'h02);
    check("bp_stable_alu_a", 32'(alu_a),      32'h01);
    // Release res_ready with the push still offered: pop happens, push does not.
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("bp_pop_no_push",  32'(fifo_count), 32'd3);
    check("bp_valid_gap",    32'(res_valid),  32'd0);
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 10 && !res_valid; n++) step();
      check($sformatf("bp_drain%0d", i), 32'(res_data), 32'(drain_exp[i]));
      step();
    end
    check("bp_drained_count", 32'(fifo_count), 32'd0);
    check("bp_drained_valid", 32'(res_valid),  32'd0);
    step();

    // ---------------- back-to-back stream ----------------
    res_ready = 1'b1;
    cmd_valid = 1'b1; cmd_a = 8'hF0; cmd_b = 8'h3C; cmd_op = 3'b010;
    step();                                   // AND accepted
    cmd_a = 8'hF0; cmd_b = 8'h0F; cmd_op = 3'b011;
    step();                                   // OR accepted, AND issued
    cmd_a = 8'h55; cmd_b = 8'h00; cmd_op = 3'b100;
    step();                                   // NOT accepted, AND captured
    cmd_valid = 1'b0;
    check("st_and_valid", 32'(res_valid), 32'd1);
    check("st_and_data",  32'(res_data),  32'h30);
    step();
    check("st_gap1",      32'(res_valid), 32'd0);
    step();
    check("st_or_valid",  32'(res_valid), 32'd1);
    check("st_or_data",   32'(res_data),  32'hFF);
    step();
    check("st_gap2",      32'(res_valid), 32'd0);
    step();
    check("st_not_valid", 32'(res_valid), 32'd1);
    check("st_not_data",  32'(res_data),  32'hAA);
    step();
    check("st_idle_valid", 32'(res_valid),  32'd0);
    check("st_idle_count", 32'(fifo_count), 32'd0);
    res_ready = 1'b0;

    // ---------------- illegal opcode ----------------
    push_cmd(8'h12, 8'h34, 3'b110);
    wait_result("illegal", 8'h00, 1'b1, 1'b1);
    check("illegal_fwd_op", 32'(alu_op), 32'd6);
    consume();
    push_cmd(8'h12, 8'h01, 3'b011);
    wait_result("legal_after", 8'h13, 1'b0, 1'b0);
    consume();
    step();

    // ---------------- reset mid-stream ----------------
    push_cmd(8'h01, 8'h02, 3'b000);
    push_cmd(8'h03, 8'h04, 3'b000);
    push_cmd(8'h05, 8'h06, 3'b000);
    push_cmd(8'h07, 8'h08, 3'b000);
    check("mid_queued", 32'(fifo_count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_count",   32'(fifo_count),  32'd0);
    check("mid_rst_ready",   32'(cmd_ready),   32'd1);
    check("mid_rst_valid",   32'(res_valid),   32'd0);
    check("mid_rst_data",    32'(res_data),    32'd0);
    check("mid_rst_alu",     32'({alu_a, alu_b, 5'(alu_op)}), 32'd0);
    check("mid_rst_flags",   32'({res_zero, res_illegal}),    32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    step();
    check("post_rst_valid", 32'(res_valid),  32'd0);
    check("post_rst_count", 32'(fifo_count), 32'd0);
    push_cmd(8'h20, 8'h22, 3'b000);
    wait_result("post_rst_add", 8'h42, 1'b0, 1'b0);
    consume();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
